// File: rtl/serv_rf_ram_dbg.sv
`default_nettype none
// ============================================================================
// Module  : serv_rf_ram_dbg
// Purpose : SERV register-file RAM with a stall-free, whole-register debug port
// Rev     : 1.0
// ============================================================================
module serv_rf_ram_dbg #(
    parameter  int width    = 8,
    parameter  int csr_regs = 4,
    localparam int raw      = $clog2(32 + csr_regs),
    localparam int l2w      = $clog2(width),
    localparam int aw       = 5 + raw - l2w,
    localparam int nb       = 32 / width
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [raw-1:0]   i_dbg_reg,
    input  logic [31:0]      i_dbg_wdata,
    output logic             o_dbg_busy,
    output logic             o_dbg_ack,
    output logic [31:0]      o_dbg_rdata
);

    localparam int CW = $clog2(nb) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [width-1:0] mem [0:(1<<aw)-1];

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [raw-1:0]   reg_q, reg_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             pend_q, pend_d;
    logic [width-1:0] cap_q, cap_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic [31:0]      dbg_rdata_q, dbg_rdata_d;

    logic [aw-1:0]    dbg_addr;
    logic [aw-1:0]    rd_addr;
    logic [width-1:0] mem_rd;
    logic [width-1:0] dbg_beat_wdata;
    logic [CW-1:0]    pend_idx;
    logic             dbg_wr_beat;
    logic             dbg_rd_beat;

    generate
        if (width == 32) begin : g_addr_reg
            assign dbg_addr = reg_q;
        end else begin : g_addr_beat
            assign dbg_addr = {reg_q, cnt_q[4-l2w:0]};
        end
    endgenerate

    // The core owns the read port whenever it asks; debug reads only fill gaps.
    assign rd_addr        = i_ren ? i_raddr : dbg_addr;
    assign mem_rd         = mem[rd_addr];
    assign dbg_beat_wdata = width'(wdata_q >> (int'(cnt_q) * width));
    assign pend_idx       = cnt_q - CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        pend_d      = 1'b0;
        cap_d       = cap_q;
        rdata_d     = rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_wr_beat = 1'b0;
        dbg_rd_beat = 1'b0;

        if (i_ren) rdata_d = mem_rd;
        // The counter has already advanced past the beat whose data sits in cap_q.
        if (pend_q) dbg_rdata_d[pend_idx*width +: width] = cap_q;

        case (state_q)
            ST_IDLE: begin
                if (i_dbg_req) begin
                    state_d = ST_RUN;
                    we_d    = i_dbg_we;
                    reg_d   = i_dbg_reg;
                    wdata_d = i_dbg_wdata;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q < CW'(nb)) begin
                    dbg_wr_beat = we_q & ~i_wen;
                    dbg_rd_beat = ~we_q & ~i_ren;
                end
                if (dbg_wr_beat | dbg_rd_beat) cnt_d = cnt_q + CW'(1);
                if (dbg_rd_beat) begin
                    pend_d = 1'b1;
                    cap_d  = mem_rd;
                end
                if (dbg_wr_beat && cnt_q == CW'(nb - 1)) state_d = ST_DONE;
                if (pend_q && cnt_q == CW'(nb)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_wen)
            mem[i_waddr] <= i_wdata;
        else if (dbg_wr_beat)
            mem[dbg_addr] <= dbg_beat_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            reg_q       <= '0;
            wdata_q     <= '0;
            pend_q      <= 1'b0;
            cap_q       <= '0;
            rdata_q     <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
            cap_q       <= cap_d;
            rdata_q     <= rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_dbg_rdata = dbg_rdata_q;
    assign o_dbg_busy  = (state_q != ST_IDLE);
    assign o_dbg_ack   = (state_q == ST_DONE);

endmodule
`default_nettype wire
